// File: rtl/pipelined_ram.sv
// pipelined_ram: dual-port block RAM with lane-masked writes, 1..3 cycle registered reads and a
// clear sweep after reset or on clear_req. Define PIPELINED_RAM_BYPASS_EN for write-first collisions.
module pipelined_ram #(
    parameter int               SIZE         = 1024,
    parameter int               WIDTH        = 8,
    parameter int               MASK_W       = 1,
    parameter int               READ_LATENCY = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE  = '0,
    localparam int              AW           = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              dbg_state,
    input  logic              write_enable,
    input  logic [AW-1:0]     write_addr,
    input  logic [MASK_W-1:0] write_mask,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              read_enable,
    input  logic [AW-1:0]     read_addr,
    output logic              read_valid,
    output logic [WIDTH-1:0]  data_out
);
    // read_valid is a one-cycle strobe with no ready: the consumer must take data_out in the
    // cycle read_valid is high. Requests are accepted only while busy is low.

    localparam int              LW        = WIDTH / MASK_W;
    localparam logic [AW:0]     SIZE_W    = (AW + 1)'(SIZE);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(SIZE - 1);

    if (MASK_W < 1 || (WIDTH % MASK_W) != 0) begin : g_bad_mask
        $error("pipelined_ram: WIDTH must be a non-zero multiple of MASK_W");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
        $error("pipelined_ram: READ_LATENCY must be 1..3");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            busy_int;

    assign busy_int  = (state_q == ST_CLEAR);
    assign busy      = busy_int;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
                else                    cnt_d   = cnt_q + AW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic              wr_in_range, rd_in_range, rd_accept;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [MASK_W-1:0] mem_wmask;

    assign wr_in_range = ({1'b0, write_addr} < SIZE_W);
    assign rd_in_range = ({1'b0, read_addr} < SIZE_W);
    assign rd_accept   = read_enable && !busy_int;

    // The single write port is shared: the sweep owns it while busy.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_addr;
        mem_wdata = data_in;
        mem_wmask = write_mask;
        if (busy_int) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = CLEAR_VALUE;
            mem_wmask = '1;
        end else if (write_enable && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    logic [WIDTH-1:0] mem [SIZE];
    logic [WIDTH-1:0] ram_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (mem_wmask[i]) mem[mem_waddr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
            end
        end
    end

    // RAM output register; read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst)            ram_q <= '0;
        else if (rd_accept) ram_q <= mem[read_addr];
    end

    logic s1_valid_q, s1_valid_d, s1_oor_q, s1_oor_d;

    always_comb begin
        s1_valid_d = rd_accept;
        s1_oor_d   = rd_accept ? !rd_in_range : s1_oor_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_oor_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_oor_q   <= s1_oor_d;
        end
    end

`ifdef PIPELINED_RAM_BYPASS_EN
    logic              s1_byp_q, s1_byp_d;
    logic [WIDTH-1:0]  s1_bdata_q, s1_bdata_d;
    logic [MASK_W-1:0] s1_bmask_q, s1_bmask_d;

    always_comb begin
        s1_byp_d   = s1_byp_q;
        s1_bdata_d = s1_bdata_q;
        s1_bmask_d = s1_bmask_q;
        if (rd_accept) begin
            s1_byp_d   = write_enable && wr_in_range && (write_addr == read_addr);
            s1_bdata_d = data_in;
            s1_bmask_d = write_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_byp_q   <= 1'b0;
            s1_bdata_q <= '0;
            s1_bmask_q <= '0;
        end else begin
            s1_byp_q   <= s1_byp_d;
            s1_bdata_q <= s1_bdata_d;
            s1_bmask_q <= s1_bmask_d;
        end
    end
`endif

    logic [WIDTH-1:0] rd_word;

    // Stage-1 word: the captured write lanes overlay the stale RAM word on a collision.
    always_comb begin
        rd_word = ram_q;
`ifdef PIPELINED_RAM_BYPASS_EN
        for (int i = 0; i < MASK_W; i++) begin
            if (s1_byp_q && s1_bmask_q[i]) rd_word[i*LW +: LW] = s1_bdata_q[i*LW +: LW];
        end
`endif
        if (s1_oor_q) rd_word = '0;
    end

    if (READ_LATENCY == 1) begin : g_lat_1
        assign read_valid = s1_valid_q;
        assign data_out   = rd_word;
    end else begin : g_lat_n
        localparam int NS = READ_LATENCY - 1;

        logic [NS-1:0]    pv_q, pv_d;
        logic [WIDTH-1:0] pd_q [NS];
        logic [WIDTH-1:0] pd_d [NS];

        // Each stage loads only when its predecessor is valid, so the last one holds between reads.
        always_comb begin
            pv_d[0] = s1_valid_q;
            pd_d[0] = s1_valid_q ? rd_word : pd_q[0];
            for (int k = 1; k < NS; k++) begin
                pv_d[k] = pv_q[k-1];
                pd_d[k] = pv_q[k-1] ? pd_q[k-1] : pd_q[k];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pv_q <= '0;
                for (int k = 0; k < NS; k++) pd_q[k] <= '0;
            end else begin
                pv_q <= pv_d;
                for (int k = 0; k < NS; k++) pd_q[k] <= pd_d[k];
            end
        end

        assign read_valid = pv_q[NS-1];
        assign data_out   = pd_q[NS-1];
    end

endmodule

// File: tb/tb_pipelined_ram.sv
// Bench for pipelined_ram: two configurations share one randomised stimulus stream and are
// scored against an array-based memory model with per-instance expected queues.
module tb_pipelined_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic        write_enable = 1'b0;
    logic [3:0]  write_addr = '0;
    logic [1:0]  write_mask = '0;
    logic [15:0] data_in = '0;
    logic        read_enable = 1'b0;
    logic [3:0]  read_addr = '0;

    logic        busy_a, dbg_a, rv_a;
    logic [15:0] do_a;
    logic        busy_b, dbg_b, rv_b;
    logic [7:0]  do_b;

    pipelined_ram #(.SIZE(12), .WIDTH(16), .MASK_W(2), .READ_LATENCY(3), .CLEAR_VALUE(16'hA5A5)) dut_a (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_a), .dbg_state(dbg_a),
        .write_enable(write_enable), .write_addr(write_addr), .write_mask(write_mask),
        .data_in(data_in), .read_enable(read_enable), .read_addr(read_addr),
        .read_valid(rv_a), .data_out(do_a));

    pipelined_ram #(.SIZE(16), .WIDTH(8), .MASK_W(1), .READ_LATENCY(1), .CLEAR_VALUE(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_b), .dbg_state(dbg_b),
        .write_enable(write_enable), .write_addr(write_addr), .write_mask(write_mask[0:0]),
        .data_in(data_in[7:0]), .read_enable(read_enable), .read_addr(read_addr),
        .read_valid(rv_b), .data_out(do_b));

    int          sz[2]    = '{12, 16};
    int          rl[2]    = '{3, 1};
    logic [15:0] clr_v[2] = '{16'hA5A5, 16'h00A5};
    logic [15:0] mem_m[2][16];
    int          busy_left[2];
    logic [15:0] last_d[2];
    logic [15:0] exp_q0[$], exp_q1[$];
    int          due_q0[$], due_q1[$];
    int          cyc = 0;
    int          checks = 0, failures = 0;

    function automatic logic [15:0] lane_bits(input int k, input logic [1:0] m);
        if (k == 0) return {{8{m[1]}}, {8{m[0]}}};
        return {8'h00, {8{m[0]}}};
    endfunction

    task automatic push(input int k, input logic [15:0] e, input int due);
        if (k == 0) begin exp_q0.push_back(e); due_q0.push_back(due); end
        else        begin exp_q1.push_back(e); due_q1.push_back(due); end
    endtask

    task automatic pop(input int k, output logic [15:0] e, output int due);
        if (k == 0) begin e = exp_q0.pop_front(); due = due_q0.pop_front(); end
        else        begin e = exp_q1.pop_front(); due = due_q1.pop_front(); end
    endtask

    // Memory model: a clear is unobservable while in progress, so it fills the array at once.
    task automatic model_step(input int k);
        logic [15:0] e, mb;
        if (rst) begin
            busy_left[k] = sz[k];
            for (int a = 0; a < 16; a++) mem_m[k][a] = clr_v[k];
            if (k == 0) begin exp_q0.delete(); due_q0.delete(); end
            else        begin exp_q1.delete(); due_q1.delete(); end
            last_d[k] = '0;
            return;
        end
        if (busy_left[k] > 0) begin
            busy_left[k]--;
            return;
        end
        mb = lane_bits(k, write_mask);
        if (read_enable) begin
            e = (int'(read_addr) < sz[k]) ? mem_m[k][read_addr] : 16'h0000;
`ifdef PIPELINED_RAM_BYPASS_EN
            if (write_enable && write_addr == read_addr && int'(read_addr) < sz[k])
                e = (e & ~mb) | (data_in & mb);
`endif
            push(k, e, cyc + rl[k] - 1);
        end
        if (write_enable && int'(write_addr) < sz[k])
            mem_m[k][write_addr] = (mem_m[k][write_addr] & ~mb) | (data_in & mb);
        if (clear_req) begin
            busy_left[k] = sz[k];
            for (int a = 0; a < 16; a++) mem_m[k][a] = clr_v[k];
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    task automatic mon(input int k, input logic v, input logic [15:0] d, input logic b, input logic st);
        logic [15:0] e;
        int          due, n;
        n = (k == 0) ? exp_q0.size() : exp_q1.size();
        checks++;
        if (b !== (busy_left[k] > 0) || st !== (busy_left[k] > 0)) begin
            failures++;
            $display("FAIL busy inst=%0d cyc=%0d got busy=%b state=%b want=%b", k, cyc, b, st, busy_left[k] > 0);
        end
        checks++;
        if (v) begin
            if (n == 0) begin
                failures++;
                $display("FAIL spurious_valid inst=%0d cyc=%0d got data=%h want no read_valid", k, cyc, d);
            end else begin
                pop(k, e, due);
                if (d !== e || due != cyc) begin
                    failures++;
                    $display("FAIL read_data inst=%0d cyc=%0d got=%h want=%h at cyc=%0d", k, cyc, d, e, due);
                end
                last_d[k] = e;
            end
        end else begin
            if (d !== last_d[k]) begin
                failures++;
                $display("FAIL hold inst=%0d cyc=%0d got=%h want=%h", k, cyc, d, last_d[k]);
            end
            if (n > 0 && ((k == 0) ? due_q0[0] : due_q1[0]) <= cyc) begin
                checks++;
                failures++;
                pop(k, e, due);
                $display("FAIL missing_valid inst=%0d cyc=%0d got read_valid=0 want data=%h", k, cyc, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            mon(0, rv_a, do_a, busy_a, dbg_a);
            mon(1, rv_b, {8'h00, do_b}, busy_b, dbg_b);
        end
    end

    task automatic drive(input logic we, input logic [3:0] wa, input logic [1:0] wm, input logic [15:0] din,
                         input logic re, input logic [3:0] ra, input logic cr);
        write_enable = we; write_addr = wa; write_mask = wm; data_in = din;
        read_enable = re;  read_addr = ra;  clear_req = cr;
        @(posedge clk);
        #1;
        write_enable = 1'b0; read_enable = 1'b0; clear_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, a, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] m, input logic [15:0] d);
        drive(1'b1, a, m, d, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && (busy_left[0] > 0 || busy_left[1] > 0); i++) idle(1);
        checks++;
        if (busy_left[0] > 0 || busy_left[1] > 0) begin
            failures++;
            $display("FAIL wait_idle cyc=%0d got still busy want idle within 64 cycles", cyc);
        end
    endtask

    initial begin
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        // Reads during the reset sweep must be dropped.
        for (int i = 0; i < 6; i++) rd(4'(i));
        wait_idle();
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(3);

        wr(4'd3, 2'b11, 16'h1234);
        wr(4'd3, 2'b01, 16'hFFFF);
        rd(4'd3);
        idle(3);

        wr(4'd0, 2'b11, 16'h0010);
        wr(4'd1, 2'b11, 16'h0011);
        wr(4'd2, 2'b11, 16'h0012);
        rd(4'd0); rd(4'd1); rd(4'd2);
        idle(5);

        wr(4'd5, 2'b11, 16'h0000);
        drive(1'b1, 4'd5, 2'b11, 16'h007E, 1'b1, 4'd5, 1'b0);
        rd(4'd5);
        drive(1'b1, 4'd5, 2'b10, 16'hAB00, 1'b1, 4'd5, 1'b0);
        rd(4'd5);
        idle(4);

        wr(4'd13, 2'b11, 16'hDEAD);
        for (int a = 0; a < 12; a++) rd(4'(a));
        rd(4'd13);
        idle(4);

        // Write and read alongside clear_req, then requests inside the sweep.
        wr(4'd7, 2'b11, 16'h5555);
        drive(1'b1, 4'd7, 2'b11, 16'h6666, 1'b1, 4'd7, 1'b1);
        idle(3);
        drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
        drive(1'b1, 4'd2, 2'b11, 16'h4444, 1'b1, 4'd2, 1'b0);
        wait_idle();
        rd(4'd7); rd(4'd2);
        idle(3);

        pulse_rst();
        idle(8);
        pulse_rst();
        idle(4);
        drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
        wait_idle();
        rd(4'd0); rd(4'd15);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 59) == 0));
            rst = 1'b0;
        end
        idle(8);

        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d/%0d reads outstanding want 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_ram.md
Name: pipelined_ram

Overview:
- Parametrised successor to the team's single-port-read frame/line memory. Dual-port RAM with write lane masking, configurable registered read latency with a valid strobe, and a hardware clear sequencer.
- Sits between the pixel writer (draw side) and the VGA scan-out fetch (read side) on a single clock domain.
- The clear sequencer replaces simulation-only initialisation with a synthesizable sweep after reset or on request.

Parameters:
- SIZE, 1024, number of words; need not be a power of two. AW = $clog2(SIZE).
- WIDTH, 8, bits per word.
- MASK_W, 1, number of write lanes. WIDTH % MASK_W must be 0; lane width LW = WIDTH/MASK_W. Elaboration error otherwise.
- READ_LATENCY, 1, cycles from read request to data; legal 1..3, elaboration error otherwise.
- CLEAR_VALUE, 0, WIDTH-bit word written to every location by the clear sequencer.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clear_req  in  1  pulse; starts a full-memory clear when idle.
- busy  out  1  high while the clear sequencer runs.
- write_enable  in  1  write strobe.
- write_addr  in  AW  write address.
- write_mask  in  MASK_W  per-lane write enable; lane i covers bits [i*LW +: LW].
- data_in  in  WIDTH  write data.
- read_enable  in  1  read request strobe.
- read_addr  in  AW  read address.
- read_valid  out  1  data_out valid this cycle.
- data_out  out  WIDTH  read data, registered.

Behaviour:
- Reset (rst high at a posedge):
  - read_valid = 0, data_out = 0, busy = 1.
  - Clear counter = 0; read pipeline flushed; FSM -> CLEAR.
- Clear FSM has two states, IDLE and CLEAR.
  - CLEAR: one word per cycle, writes CLEAR_VALUE to address cnt with all lanes enabled, cnt increments. When cnt == SIZE-1 has been written, FSM -> IDLE and busy = 0 on the next cycle.
  - Clear of SIZE words takes exactly SIZE cycles after rst deasserts; busy is high for those SIZE cycles.
  - IDLE: clear_req = 1 -> CLEAR, cnt = 0, busy = 1 from the next cycle.
  - clear_req while in CLEAR is ignored; there is no restart.
  - rst asserted mid-clear restarts the sweep from address 0.
- User accesses while busy:
  - Writes are dropped.
  - Read requests are dropped: no read_valid is generated for them.
  - Reads already in the pipeline when the clear starts complete normally.
- Writes (IDLE, write_enable = 1):
  - Lane i is updated from data_in at the posedge only if write_mask[i] = 1; other lanes are retained.
  - write_mask = 0 is a no-op.
- Reads (IDLE, read_enable = 1 at cycle t with address A):
  - At cycle t + READ_LATENCY, read_valid = 1 and data_out = mem[A] as sampled at cycle t.
  - One read per cycle; fully pipelined; back-to-back reads give back-to-back valids.
  - data_out holds its last value while read_valid = 0.
- Out of range (address >= SIZE, non-power-of-two SIZE only):
  - Writes are ignored.
  - Reads return all-zeros with read_valid asserted normally.
- Same cycle, same address, read and write: read-first, i.e. data_out returns the old word (see Optional Feature).
- A write in the same cycle as clear_req in IDLE is committed; the clear starts next cycle and overwrites it.
- Storage must infer block RAM. No asynchronous read path; the first pipeline stage is the RAM output register.

Optional Feature:
- Macro: PIPELINED_RAM_BYPASS_EN.
- Defined: write-first forwarding. For a same-cycle read and write to the same address, data_out returns the new word: masked lanes from data_in, unmasked lanes from stored data. Latency is still READ_LATENCY.
- Undefined: read-first behaviour as described above. No forwarding logic is instantiated.

Test Plan:
- Reset clear: SIZE=16, CLEAR_VALUE=8'hA5; pulse rst one cycle.
  - busy is high exactly 16 cycles.
  - Then reads of addresses 0..15 all return 8'hA5.
  - A read issued during busy produces no read_valid.
- Masked write: WIDTH=16, MASK_W=2; write 16'h1234 to address 3, then write 16'hFFFF with mask 2'b01.
  - A read of address 3 returns 16'h12FF.
- Latency: READ_LATENCY=3; issue back-to-back reads of addresses 0,1,2 holding 0x10, 0x11, 0x12 at cycles t..t+2.
  - read_valid is high at t+3..t+5 with data 0x10, 0x11, 0x12.
  - read_valid is low at t+6 and data_out holds 0x12.
- Collision: address 5 holds 0x00; in the same cycle write 0x7E and read address 5.
  - Returns 0x00 without PIPELINED_RAM_BYPASS_EN, 0x7E with it.
  - The next read of address 5 returns 0x7E in both builds.
- Mid-clear reset and request: SIZE=16.
  - Assert rst at clear cycle 8 -> sweep restarts at address 0; total busy = 16 cycles after rst falls.
  - clear_req pulsed during busy is ignored (busy does not extend).
- Out of range: SIZE=12.
  - A write to address 13 leaves addresses 0..11 unchanged.
  - A read of address 13 returns 0 with read_valid = 1.
